// File: rtl/config_pkg.sv
// Shared constants for the ALU response serializer.
// Holds the response state encoding, header layout constants and the opcode
// values the UART ALU datapath echoes back in response headers.
package config_pkg;

   // Fixed response header: opcode, reserved, length LSB, length MSB.
   localparam int unsigned HDR_BYTES     = 4;
   localparam logic [7:0]  RESP_RSV_BYTE = 8'h00;

   localparam logic [7:0] OP_ECHO = 8'hEC;
   localparam logic [7:0] OP_ADD  = 8'hAD;
   localparam logic [7:0] OP_MUL  = 8'hAC;
   localparam logic [7:0] OP_DIV  = 8'hD1;

   // Response states, kept as plain constants so legacy code can compare raw codes.
   typedef logic [2:0] resp_state_e;
   localparam resp_state_e StIdle     = 3'd0;
   localparam resp_state_e StHdrOp    = 3'd1;
   localparam resp_state_e StHdrRsv   = 3'd2;
   localparam resp_state_e StHdrLenLo = 3'd3;
   localparam resp_state_e StHdrLenHi = 3'd4;
   localparam resp_state_e StPayload  = 3'd5;
   localparam resp_state_e StChecksum = 3'd6;

endpackage

// File: rtl/alu_resp_serializer_byte_mux.sv
// resp_byte_mux: selects the response byte presented to the UART transmitter.
// Purely combinational; the FSM and index counter live in alu_resp_serializer.
// Optional feature macro: ALU_RESP_CHECKSUM_EN (adds the checksum byte source).
// Ports:
//   state_i   current response state
//   opcode_i  latched opcode
//   result_i  latched 64-bit result, byte 0 in [7:0]
//   len_i     packet length L
//   k_i       payload byte index
//   csum_i    running XOR of transmitted bytes (checksum builds only)
//   data_o    byte to transmit (0 while idle)
module resp_byte_mux
   import config_pkg::*;
(
   input  resp_state_e  state_i,
   input  logic [7:0]   opcode_i,
   input  logic [63:0]  result_i,
   input  logic [15:0]  len_i,
   input  logic [2:0]   k_i,
`ifdef ALU_RESP_CHECKSUM_EN
   input  logic [7:0]   csum_i,
`endif
   output logic [7:0]   data_o
);

   always_comb begin
      data_o = 8'h00;
      case (state_i)
         StHdrOp:    data_o = opcode_i;
         StHdrRsv:   data_o = RESP_RSV_BYTE;
         StHdrLenLo: data_o = len_i[7:0];
         StHdrLenHi: data_o = len_i[15:8];
         StPayload:  data_o = result_i[{k_i, 3'b000} +: 8];
`ifdef ALU_RESP_CHECKSUM_EN
         StChecksum: data_o = csum_i;
`endif
         default:    data_o = 8'h00;
      endcase
   end

endmodule

// File: rtl/alu_resp_serializer.sv
// alu_resp_serializer: response side of the UART ALU datapath.
// Accepts one ALU result per valid/ready handshake and streams it as
//   opcode, 0x00, L[7:0], L[15:8], payload bytes LSB-first [, checksum]
// one byte at a time over a valid/ready byte interface.
// Optional feature macro: ALU_RESP_CHECKSUM_EN appends the XOR of all
// transmitted bytes and counts it in L.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   opcode_i            opcode echoed in the header
//   result_i            ALU result, byte 0 = result_i[7:0]
//   result_bytes_i      payload byte count, clamped to MAX_BYTES_P
//   result_valid_i      result fields valid
//   result_ready_o      serializer idle and able to accept
//   tx_data_o           byte to the UART transmitter
//   tx_valid_o          tx_data_o valid
//   tx_ready_i          transmitter accepts the byte
//   busy_o              packet in flight
module alu_resp_serializer
   import config_pkg::*;
#(
   parameter int unsigned MAX_BYTES_P = 8,
   parameter int unsigned HDR_BYTES_P = HDR_BYTES
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  opcode_i,
   input  logic [63:0] result_i,
   input  logic [3:0]  result_bytes_i,
   input  logic        result_valid_i,
   output logic        result_ready_o,
   output logic [7:0]  tx_data_o,
   output logic        tx_valid_o,
   input  logic        tx_ready_i,
   output logic        busy_o
);

   localparam logic [3:0] MaxBytes = 4'(MAX_BYTES_P);

`ifdef ALU_RESP_CHECKSUM_EN
   localparam logic [15:0] CsumBytes = 16'd1;
   localparam resp_state_e StAfterBody = StChecksum;
`else
   localparam logic [15:0] CsumBytes = 16'd0;
   localparam resp_state_e StAfterBody = StIdle;
`endif

   resp_state_e state_q, state_d;
   logic [7:0]  opcode_q, opcode_d;
   logic [63:0] result_q, result_d;
   logic [3:0]  n_q, n_d;
   logic [2:0]  k_q, k_d;
`ifdef ALU_RESP_CHECKSUM_EN
   logic [7:0]  csum_q, csum_d;
`endif

   logic        accept;
   logic        tx_hs;
   logic        last_payload;
   logic [3:0]  n_clamped;
   logic [15:0] len;

   assign result_ready_o = (state_q == StIdle);
   assign tx_valid_o     = (state_q != StIdle);
   assign busy_o         = (state_q != StIdle);

   assign accept       = result_valid_i & result_ready_o;
   assign tx_hs        = tx_valid_o & tx_ready_i;
   assign n_clamped    = (result_bytes_i > MaxBytes) ? MaxBytes : result_bytes_i;
   assign last_payload = ({1'b0, k_q} == (n_q - 4'd1));
   assign len          = 16'(HDR_BYTES_P) + {12'h000, n_q} + CsumBytes;

   always_comb begin
      state_d  = state_q;
      opcode_d = opcode_q;
      result_d = result_q;
      n_d      = n_q;
      k_d      = k_q;
`ifdef ALU_RESP_CHECKSUM_EN
      csum_d   = csum_q;
      if (tx_hs) begin
         csum_d = csum_q ^ tx_data_o;
      end
`endif
      case (state_q)
         StIdle: begin
            if (accept) begin
               opcode_d = opcode_i;
               result_d = result_i;
               n_d      = n_clamped;
               k_d      = 3'd0;
`ifdef ALU_RESP_CHECKSUM_EN
               csum_d   = 8'h00;
`endif
               state_d  = StHdrOp;
            end
         end
         StHdrOp:    if (tx_hs) state_d = StHdrRsv;
         StHdrRsv:   if (tx_hs) state_d = StHdrLenLo;
         StHdrLenLo: if (tx_hs) state_d = StHdrLenHi;
         StHdrLenHi: begin
            if (tx_hs) begin
               state_d = (n_q == 4'd0) ? StAfterBody : StPayload;
            end
         end
         StPayload: begin
            if (tx_hs) begin
               if (last_payload) begin
                  state_d = StAfterBody;
               end else begin
                  k_d = k_q + 3'd1;
               end
            end
         end
`ifdef ALU_RESP_CHECKSUM_EN
         StChecksum: if (tx_hs) state_d = StIdle;
`endif
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         opcode_q <= 8'h00;
         result_q <= 64'h0;
         n_q      <= 4'd0;
         k_q      <= 3'd0;
`ifdef ALU_RESP_CHECKSUM_EN
         csum_q   <= 8'h00;
`endif
      end else begin
         state_q  <= state_d;
         opcode_q <= opcode_d;
         result_q <= result_d;
         n_q      <= n_d;
         k_q      <= k_d;
`ifdef ALU_RESP_CHECKSUM_EN
         csum_q   <= csum_d;
`endif
      end
   end

   resp_byte_mux u_byte_mux (
      .state_i  (state_q),
      .opcode_i (opcode_q),
      .result_i (result_q),
      .len_i    (len),
      .k_i      (k_q),
`ifdef ALU_RESP_CHECKSUM_EN
      .csum_i   (csum_q),
`endif
      .data_o   (tx_data_o)
   );

endmodule

// File: tb/tb_alu_resp_serializer.sv
// Self-checking bench for alu_resp_serializer: a packet-level queue model
// predicts every output each cycle; directed packets pin literal byte streams.
module tb_alu_resp_serializer;

   localparam int unsigned MaxBytes = 8;
`ifdef ALU_RESP_CHECKSUM_EN
   localparam int CsumEn = 1;
`else
   localparam int CsumEn = 0;
`endif

   logic        clk;
   logic        rst;
   logic [7:0]  opcode_i;
   logic [63:0] result_i;
   logic [3:0]  result_bytes_i;
   logic        result_valid_i;
   logic        result_ready_o;
   logic [7:0]  tx_data_o;
   logic        tx_valid_o;
   logic        tx_ready_i;
   logic        busy_o;

   alu_resp_serializer #(
      .MAX_BYTES_P (MaxBytes)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .opcode_i       (opcode_i),
      .result_i       (result_i),
      .result_bytes_i (result_bytes_i),
      .result_valid_i (result_valid_i),
      .result_ready_o (result_ready_o),
      .tx_data_o      (tx_data_o),
      .tx_valid_o     (tx_valid_o),
      .tx_ready_i     (tx_ready_i),
      .busy_o         (busy_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int compared   = 0;
   int mismatched = 0;

   logic [7:0] model_q[$];
   bit         model_live = 0;
   logic [7:0] got_q[$];
   int         run_len  = 0;
   int         last_run = 0;
   int         tx_mode  = 0;
   int         pat_idx  = 0;

   // Whole packet as the transmitter must see it.
   task automatic build_packet(input logic [7:0] op, input logic [63:0] res,
                               input logic [3:0] cnt);
      int n;
      logic [7:0] x;
      n = int'(cnt);
      if (n > int'(MaxBytes)) n = int'(MaxBytes);
      model_q.push_back(op);
      model_q.push_back(8'h00);
      model_q.push_back(8'(4 + n + CsumEn));
      model_q.push_back(8'h00);
      for (int i = 0; i < n; i++) model_q.push_back(res[8*i +: 8]);
      if (CsumEn != 0) begin
         x = 8'h00;
         foreach (model_q[i]) x = x ^ model_q[i];
         model_q.push_back(x);
      end
   endtask

   // Model: idle when queue empty; accepts on valid, pops on transmitter ready.
   initial begin
      forever begin
         @(posedge clk);
         if (rst) begin
            model_q.delete();
            model_live = 1;
         end else if (model_q.size() == 0) begin
            if (result_valid_i) build_packet(opcode_i, result_i, result_bytes_i);
         end else if (tx_ready_i) begin
            void'(model_q.pop_front());
         end
      end
   end

   // Per-cycle compare, sampled mid-low-phase after inputs settle.
   initial begin
      logic       ev;
      logic [7:0] ed;
      forever begin
         @(negedge clk);
         #2;
         if (model_live) begin
            ev = (model_q.size() != 0);
            ed = ev ? model_q[0] : 8'h00;
            compared++;
            if (tx_valid_o !== ev || tx_data_o !== ed || result_ready_o !== !ev ||
                busy_o !== ev) begin
               mismatched++;
               $display("FAIL cycle_outputs t=%0t: valid/data/ready/busy got %b/%h/%b/%b expected %b/%h/%b/%b",
                        $time, tx_valid_o, tx_data_o, result_ready_o, busy_o,
                        ev, ed, !ev, ev);
            end
         end
         if (!rst && tx_valid_o && tx_ready_i) got_q.push_back(tx_data_o);
         if (tx_valid_o) begin
            run_len++;
         end else begin
            if (run_len > 0) last_run = run_len;
            run_len = 0;
         end
      end
   end

   // Transmitter ready: 0 always, 1 pattern 1,0,0,1, 2 random.
   initial begin
      logic [3:0] pat;
      pat = 4'b1001;
      forever begin
         @(negedge clk);
         case (tx_mode)
            0: tx_ready_i = 1'b1;
            1: begin
               tx_ready_i = pat[3 - (pat_idx % 4)];
               pat_idx++;
            end
            default: tx_ready_i = (($urandom % 4) != 0);
         endcase
      end
   end

   task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_bytes(input string name, input logic [7:0] exp[$]);
      compared++;
      if (got_q.size() != exp.size()) begin
         mismatched++;
         $display("FAIL %s length: got %0d bytes expected %0d", name, got_q.size(), exp.size());
      end
      for (int i = 0; i < exp.size(); i++) begin
         if (i < got_q.size()) begin
            compared++;
            if (got_q[i] !== exp[i]) begin
               mismatched++;
               $display("FAIL %s byte %0d: got %h expected %h", name, i, got_q[i], exp[i]);
            end
         end
      end
   endtask

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic send(input logic [7:0] op, input logic [63:0] res, input logic [3:0] cnt,
                       input bit hold);
      bit ok;
      ok = 0;
      opcode_i       = op;
      result_i       = res;
      result_bytes_i = cnt;
      result_valid_i = 1'b1;
      for (int i = 0; i < 2000; i++) begin
         if (result_ready_o) begin
            ok = 1;
            break;
         end
         @(negedge clk);
      end
      if (!ok) begin
         compared++;
         mismatched++;
         $display("FAIL accept_timeout: got no ready expected ready within 2000 cycles");
      end
      @(negedge clk);
      if (!hold) result_valid_i = 1'b0;
   endtask

   task automatic wait_idle();
      bit ok;
      ok = 0;
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         if (!busy_o) begin
            ok = 1;
            break;
         end
      end
      if (!ok) begin
         compared++;
         mismatched++;
         $display("FAIL idle_timeout: got busy expected idle within 4000 cycles");
      end
      @(negedge clk);
   endtask

   initial begin
      logic [7:0] exp_q[$];
      rst            = 1'b1;
      opcode_i       = 8'h00;
      result_i       = 64'h0;
      result_bytes_i = 4'd0;
      result_valid_i = 1'b0;
      tx_ready_i     = 1'b1;
      repeat (3) @(negedge clk);
      check_eq("reset_ready", 32'(result_ready_o), 32'd1);
      check_eq("reset_valid", 32'(tx_valid_o), 32'd0);
      check_eq("reset_data",  32'(tx_data_o), 32'd0);
      check_eq("reset_busy",  32'(busy_o), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // ADD, 4 bytes, transmitter always ready.
      got_q.delete();
      send(8'hAD, 64'h0000_0000_1234_5678, 4'd4, 1'b0);
      wait_idle();
`ifdef ALU_RESP_CHECKSUM_EN
      exp_q = '{8'hAD, 8'h00, 8'h09, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hAC};
`else
      exp_q = '{8'hAD, 8'h00, 8'h08, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
`endif
      check_bytes("add4", exp_q);
      check_eq("add4_valid_run", 32'(last_run), 32'(8 + CsumEn));

      // MUL, 8 bytes, transmitter stalls in a 1,0,0,1 pattern.
      tx_mode = 1;
      got_q.delete();
      send(8'hAC, 64'h0102_0304_0506_0708, 4'd8, 1'b0);
      wait_idle();
      tx_mode = 0;
`ifdef ALU_RESP_CHECKSUM_EN
      exp_q = '{8'hAC, 8'h00, 8'h0D, 8'h00, 8'h08, 8'h07, 8'h06, 8'h05, 8'h04,
                8'h03, 8'h02, 8'h01, 8'hA9};
`else
      exp_q = '{8'hAC, 8'h00, 8'h0C, 8'h00, 8'h08, 8'h07, 8'h06, 8'h05, 8'h04,
                8'h03, 8'h02, 8'h01};
`endif
      check_bytes("mul8_stall", exp_q);

      // Zero count: header only.
      got_q.delete();
      send(8'hEC, 64'hFFFF_FFFF_FFFF_FFFF, 4'd0, 1'b0);
      wait_idle();
`ifdef ALU_RESP_CHECKSUM_EN
      exp_q = '{8'hEC, 8'h00, 8'h05, 8'h00, 8'hE9};
`else
      exp_q = '{8'hEC, 8'h00, 8'h04, 8'h00};
`endif
      check_bytes("echo0", exp_q);

      // Count 12 clamps to 8.
      got_q.delete();
      send(8'hD1, 64'h1122_3344_5566_7788, 4'd12, 1'b0);
      wait_idle();
      check_eq("clamp_len_lo", 32'(got_q.size() > 2 ? got_q[2] : 8'hFF), 32'(12 + CsumEn));
      check_eq("clamp_count",  32'(got_q.size()), 32'(12 + CsumEn));

      // Back-to-back: second result queued behind the first.
      send(8'hAD, 64'h0000_0000_00AA_BBCC, 4'd3, 1'b1);
      send(8'hAC, 64'h0000_0000_0000_DDEE, 4'd2, 1'b0);
      wait_idle();

      // Reset during payload byte k=2.
      send(8'hAD, 64'h8877_6655_4433_2211, 4'd8, 1'b0);
      repeat (6) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_eq("midrst_valid", 32'(tx_valid_o), 32'd0);
      check_eq("midrst_ready", 32'(result_ready_o), 32'd1);
      check_eq("midrst_busy",  32'(busy_o), 32'd0);
      got_q.delete();
      send(8'hEC, 64'h0000_0000_0000_BEEF, 4'd2, 1'b0);
      wait_idle();
`ifdef ALU_RESP_CHECKSUM_EN
      exp_q = '{8'hEC, 8'h00, 8'h07, 8'h00, 8'hEF, 8'hBE, 8'hBA};
`else
      exp_q = '{8'hEC, 8'h00, 8'h06, 8'h00, 8'hEF, 8'hBE};
`endif
      check_bytes("post_rst", exp_q);

      // Single payload byte.
      got_q.delete();
      send(8'hAD, 64'h0000_0000_0000_0005, 4'd1, 1'b0);
      wait_idle();
`ifdef ALU_RESP_CHECKSUM_EN
      exp_q = '{8'hAD, 8'h00, 8'h06, 8'h00, 8'h05, 8'hAE};
`else
      exp_q = '{8'hAD, 8'h00, 8'h05, 8'h00, 8'h05};
`endif
      check_bytes("add1", exp_q);

      // Randomized traffic with random transmitter backpressure.
      tx_mode = 2;
      for (int p = 0; p < 40; p++) begin
         logic [7:0] op;
         repeat ($urandom % 3) @(negedge clk);
         case ($urandom % 5)
            0: op = 8'hEC;
            1: op = 8'hAD;
            2: op = 8'hAC;
            3: op = 8'hD1;
            default: op = 8'($urandom);
         endcase
         send(op, {$urandom, $urandom}, 4'($urandom % 16), 1'(($urandom % 2)));
      end
      result_valid_i = 1'b0;
      wait_idle();
      tx_mode = 0;
      repeat (3) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
